// File: rtl/k_counter.sv
// k_counter: DPLL loop filter feeding the IDCounter (DCO).
//
// Two modulo-K counters integrate the phase-detector direction bit. Overflow of
// the up-counter raises a carry event and overflow of the down-counter raises
// a borrow event. Each event becomes a one-cycle inc/dec pulse. Pulses are
// spaced at least MIN_GAP cycles apart. Events that arrive inside the gap are
// held as pending, and pending events of opposite direction cancel.
//
// Ports:
//   clk      in   1           system clock, rising edge
//   reset    in   1           synchronous, active-high reset
//   enable   in   1           count enable (gates the two K counters only)
//   dn_up    in   1           0 = advance up-counter, 1 = advance down-counter
//   k_sel    in   KSEL_WIDTH  modulus select, K = 2^k_sel clamped to [3, CNT_WIDTH]
//   inc      out  1           one-cycle pulse to DCO inc
//   dec      out  1           one-cycle pulse to DCO dec
//   pending  out  1           an inc or dec event is waiting for the gap to expire
//   drop     out  1           one-cycle pulse: an event was lost to an already pending one
module k_counter #(
  parameter int CNT_WIDTH  = 16,
  parameter int KSEL_WIDTH = 5,
  parameter int MIN_GAP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dn_up,
  input  logic [KSEL_WIDTH-1:0] k_sel,
  output logic                  inc,
  output logic                  dec,
  output logic                  pending,
  output logic                  drop
);

  localparam int                   GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE  = GAP_W'(32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

  logic [CNT_WIDTH-1:0] up_cnt_r, up_cnt_s;
  logic [CNT_WIDTH-1:0] dn_cnt_r, dn_cnt_s;
  logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
  logic                 pend_inc_r, pend_inc_s;
  logic                 pend_dec_r, pend_dec_s;
  logic                 inc_r, inc_s;
  logic                 dec_r, dec_s;
  logic                 drop_r, drop_s;
  logic                 pending_r, pending_s;

  logic [31:0]          ksel_ext_s;
  logic [31:0]          keff_s;
  logic [CNT_WIDTH-1:0] kmax_s;
  logic                 up_at_max_s, dn_at_max_s;
  logic                 carry_s, borrow_s;
  logic                 gap_zero_s;
  logic                 pi_post_s, pd_post_s;

  // Clamp the modulus select and derive the terminal count K-1 as a mask.
  always_comb begin
    ksel_ext_s = 32'(k_sel);
    if (ksel_ext_s < 32'd3) begin
      keff_s = 32'd3;
    end else if (ksel_ext_s > 32'(CNT_WIDTH)) begin
      keff_s = 32'(CNT_WIDTH);
    end else begin
      keff_s = ksel_ext_s;
    end
    kmax_s = {CNT_WIDTH{1'b1}} >> (32'(CNT_WIDTH) - keff_s);
  end

  // '>=' rather than '==' so that shrinking K below the current count
  // wraps on the next enabled count instead of running to 2^CNT_WIDTH.
  assign up_at_max_s = (up_cnt_r >= kmax_s);
  assign dn_at_max_s = (dn_cnt_r >= kmax_s);
  assign carry_s     = enable & ~dn_up & up_at_max_s;
  assign borrow_s    = enable &  dn_up & dn_at_max_s;

  // Next value of the two K counters; only the selected one advances.
  always_comb begin
    up_cnt_s = up_cnt_r;
    dn_cnt_s = dn_cnt_r;
    if (enable) begin
      if (!dn_up) begin
        if (up_at_max_s) begin
          up_cnt_s = {CNT_WIDTH{1'b0}};
        end else begin
          up_cnt_s = up_cnt_r + CNT_ONE;
        end
      end else begin
        if (dn_at_max_s) begin
          dn_cnt_s = {CNT_WIDTH{1'b0}};
        end else begin
          dn_cnt_s = dn_cnt_r + CNT_ONE;
        end
      end
    end else begin
      up_cnt_s = up_cnt_r;
      dn_cnt_s = dn_cnt_r;
    end
  end

  // Emission stage: release one pending event when the gap has expired.
  // Inc wins over dec, though both are never pending together.
  always_comb begin
    gap_zero_s = (gap_cnt_r == {GAP_W{1'b0}});
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    pi_post_s  = pend_inc_r;
    pd_post_s  = pend_dec_r;
    gap_cnt_s  = gap_cnt_r;
    if (gap_zero_s && pend_inc_r) begin
      inc_s     = 1'b1;
      pi_post_s = 1'b0;
      gap_cnt_s = GAP_LOAD;
    end else if (gap_zero_s && pend_dec_r) begin
      dec_s     = 1'b1;
      pd_post_s = 1'b0;
      gap_cnt_s = GAP_LOAD;
    end else if (!gap_zero_s) begin
      gap_cnt_s = gap_cnt_r - GAP_ONE;
    end else begin
      gap_cnt_s = gap_cnt_r;
    end
  end

  // Event stage: fold this edge's carry/borrow into the post-emission pending state.
  always_comb begin
    pend_inc_s = pi_post_s;
    pend_dec_s = pd_post_s;
    drop_s     = 1'b0;
    if (carry_s) begin
      if (pd_post_s) begin
        pend_dec_s = 1'b0;
      end else if (pi_post_s) begin
        drop_s = 1'b1;
      end else begin
        pend_inc_s = 1'b1;
      end
    end else if (borrow_s) begin
      if (pi_post_s) begin
        pend_inc_s = 1'b0;
      end else if (pd_post_s) begin
        drop_s = 1'b1;
      end else begin
        pend_dec_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end
    pending_s = pend_inc_s | pend_dec_s;
  end

  // State and output registers; reset overrides any event at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_cnt_r   <= {CNT_WIDTH{1'b0}};
      dn_cnt_r   <= {CNT_WIDTH{1'b0}};
      gap_cnt_r  <= {GAP_W{1'b0}};
      pend_inc_r <= 1'b0;
      pend_dec_r <= 1'b0;
      inc_r      <= 1'b0;
      dec_r      <= 1'b0;
      drop_r     <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      up_cnt_r   <= up_cnt_s;
      dn_cnt_r   <= dn_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      pend_inc_r <= pend_inc_s;
      pend_dec_r <= pend_dec_s;
      inc_r      <= inc_s;
      dec_r      <= dec_s;
      drop_r     <= drop_s;
      pending_r  <= pending_s;
    end
  end

  assign inc     = inc_r;
  assign dec     = dec_r;
  assign pending = pending_r;
  assign drop    = drop_r;

endmodule

// File: tb/tb_k_counter.sv
// tb_k_counter: directed, table-driven bench for k_counter.
// Three instances share the stimulus (MIN_GAP = 4, 16, 32); each table row
// names the instance whose outputs {inc, dec, pending, drop} are compared.
module tb_k_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       dn_up;
  logic [4:0] k_sel;

  logic inc0, dec0, pend0, drop0;
  logic inc1, dec1, pend1, drop1;
  logic inc2, dec2, pend2, drop2;
  logic [3:0] obs [3];

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] E0  = 4'b0000;
  localparam logic [3:0] EI  = 4'b1000;
  localparam logic [3:0] ED  = 4'b0100;
  localparam logic [3:0] EP  = 4'b0010;
  localparam logic [3:0] EPD = 4'b0011;

  typedef struct {
    int unsigned n;
    logic        rst;
    logic        en;
    logic        dn;
    logic [4:0]  ks;
    int unsigned sel;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[$];

  k_counter #(.CNT_WIDTH(16), .KSEL_WIDTH(5), .MIN_GAP(4)) u_g4 (
    .clk(clk), .reset(reset), .enable(enable), .dn_up(dn_up), .k_sel(k_sel),
    .inc(inc0), .dec(dec0), .pending(pend0), .drop(drop0));

  k_counter #(.CNT_WIDTH(16), .KSEL_WIDTH(5), .MIN_GAP(16)) u_g16 (
    .clk(clk), .reset(reset), .enable(enable), .dn_up(dn_up), .k_sel(k_sel),
    .inc(inc1), .dec(dec1), .pending(pend1), .drop(drop1));

  k_counter #(.CNT_WIDTH(16), .KSEL_WIDTH(5), .MIN_GAP(32)) u_g32 (
    .clk(clk), .reset(reset), .enable(enable), .dn_up(dn_up), .k_sel(k_sel),
    .inc(inc2), .dec(dec2), .pending(pend2), .drop(drop2));

  assign obs[0] = {inc0, dec0, pend0, drop0};
  assign obs[1] = {inc1, dec1, pend1, drop1};
  assign obs[2] = {inc2, dec2, pend2, drop2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(int unsigned n, logic r, logic e, logic d,
                              logic [4:0] k, int unsigned s, logic [3:0] x);
    vec_t v;
    v.n = n; v.rst = r; v.en = e; v.dn = d; v.ks = k; v.sel = s; v.exp = x;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {inc,dec,pending,drop} got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, and settle just after it.
  task automatic step(input logic r, input logic e, input logic d, input logic [4:0] k);
    reset  = r;
    enable = e;
    dn_up  = d;
    k_sel  = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; dn_up = 1'b0; k_sel = 5'd3;

    // Reset held 3 cycles with counting requested: everything stays 0.
    add(3, 1'b1, 1'b1, 1'b0, 5'd3, 0, E0);
    // K=8 up-counting, MIN_GAP=4: carry at edge 8, inc at edge 9, period 8.
    add(7, 1'b0, 1'b1, 1'b0, 5'd3, 0, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EI);
    add(6, 1'b0, 1'b1, 1'b0, 5'd3, 0, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EI);
    add(6, 1'b0, 1'b1, 1'b0, 5'd3, 0, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 0, EI);
    // Same in the down direction: dec pulses with period 8.
    add(2, 1'b1, 1'b1, 1'b1, 5'd3, 0, E0);
    add(7, 1'b0, 1'b1, 1'b1, 5'd3, 0, E0);
    add(1, 1'b0, 1'b1, 1'b1, 5'd3, 0, EP);
    add(1, 1'b0, 1'b1, 1'b1, 5'd3, 0, ED);
    add(6, 1'b0, 1'b1, 1'b1, 5'd3, 0, E0);
    add(1, 1'b0, 1'b1, 1'b1, 5'd3, 0, EP);
    add(1, 1'b0, 1'b1, 1'b1, 5'd3, 0, ED);
    // k_sel=0 clamps to K=8.
    add(2, 1'b1, 1'b0, 1'b0, 5'd0, 0, E0);
    add(7, 1'b0, 1'b1, 1'b0, 5'd0, 0, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd0, 0, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd0, 0, EI);
    // k_sel=31 clamps to K=65536: first carry on the 65536th enabled edge.
    add(2, 1'b1, 1'b0, 1'b0, 5'd31, 0, E0);
    add(65535, 1'b0, 1'b1, 1'b0, 5'd31, 0, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd31, 0, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd31, 0, EI);
    // MIN_GAP=16: second carry pends, a borrow cancels it, nothing is emitted.
    add(2, 1'b1, 1'b0, 1'b0, 5'd3, 1, E0);
    add(7, 1'b0, 1'b1, 1'b0, 5'd3, 1, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 1, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 1, EI);
    add(6, 1'b0, 1'b1, 1'b0, 5'd3, 1, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 1, EP);
    add(7, 1'b0, 1'b1, 1'b1, 5'd3, 1, EP);
    add(1, 1'b0, 1'b1, 1'b1, 5'd3, 1, E0);
    add(20, 1'b0, 1'b0, 1'b1, 5'd3, 1, E0);
    // MIN_GAP=32: third carry drops, the pending inc is released at edge 41.
    add(2, 1'b1, 1'b0, 1'b0, 5'd3, 2, E0);
    add(7, 1'b0, 1'b1, 1'b0, 5'd3, 2, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 2, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 2, EI);
    add(6, 1'b0, 1'b1, 1'b0, 5'd3, 2, E0);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 2, EP);
    add(7, 1'b0, 1'b1, 1'b0, 5'd3, 2, EP);
    add(1, 1'b0, 1'b1, 1'b0, 5'd3, 2, EPD);
    add(16, 1'b0, 1'b0, 1'b0, 5'd3, 2, EP);
    add(1, 1'b0, 1'b0, 1'b0, 5'd3, 2, EI);
    add(10, 1'b0, 1'b0, 1'b0, 5'd3, 2, E0);

    foreach (tbl[i]) begin
      for (int c = 0; c < int'(tbl[i].n); c++) begin
        step(tbl[i].rst, tbl[i].en, tbl[i].dn, tbl[i].ks);
        chk($sformatf("row%0d_cyc%0d", i, c), obs[tbl[i].sel], tbl[i].exp);
      end
    end

    // Reset while an event is pending: cleared with no pulse, and nothing follows.
    for (int c = 0; c < 2; c++) step(1'b1, 1'b0, 1'b0, 5'd3);
    for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 1'b0, 5'd3);
    step(1'b0, 1'b1, 1'b0, 5'd3);
    chk("rstpend_set", obs[0], EP);
    step(1'b1, 1'b1, 1'b0, 5'd3);
    chk("rstpend_clear", obs[0], E0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b0, 5'd3);
      chk($sformatf("rstpend_quiet%0d", c), obs[0], E0);
    end

    // Shrinking K below the current count wraps on the next enabled count.
    for (int c = 0; c < 2; c++) step(1'b1, 1'b0, 1'b0, 5'd4);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 1'b0, 5'd4);
      chk($sformatf("kshrink_k16_%0d", c), obs[0], E0);
    end
    step(1'b0, 1'b1, 1'b0, 5'd3);
    chk("kshrink_wrap", obs[0], EP);
    step(1'b0, 1'b0, 1'b0, 5'd3);
    chk("kshrink_inc", obs[0], EI);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
